// File: rtl/axil_axis_pkg.sv
// Shared constants and types for the AXI-Lite / AXI-Stream gain responder.
package axil_axis_pkg;

  localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
  localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
  localparam logic [11:0] ADDR_GAIN     = 12'h020;

  localparam int AP_START_BIT  = 0;
  localparam int AP_DONE_BIT   = 1;
  localparam int AP_IDLE_BIT   = 2;
  localparam int TLAST_ERR_BIT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/axil_axis_responder_if.sv
// Bus bundle for the responder: AXI-Lite AW/W/AR/R plus the ss_* sink and sm_* source streams.
interface axil_axis_responder_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/axis_sync_fifo.sv
// Small synchronous FIFO; a pop in the same cycle frees a slot for a push into a full FIFO.
module axis_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             wbs_clk_i,
  input  logic             wbs_rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Extra pointer MSB distinguishes full from empty
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign pop_data  = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointers; reset flushes every entry
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1'b1);
      end
    end
  end

endmodule

// File: rtl/axil_axis_responder.sv
// Gain responder: AXI-Lite control registers plus an AXI-Stream multiply-and-return path.
// Each block of data_length samples ends with sm_tlast and ap_done.
module axil_axis_responder
  import axil_axis_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                  wbs_clk_i,
  input logic                  wbs_rst_i,
  axil_axis_responder_if.slave bus
);
  localparam logic [pADDR_WIDTH-1:0] WORD_MASK = ~pADDR_WIDTH'(2'b11);
  localparam logic [pDATA_WIDTH-1:0] ONE       = pDATA_WIDTH'(1'b1);

  function automatic logic addr_hit(input logic [pADDR_WIDTH-1:0] addr, input logic [11:0] base);
    return (addr & WORD_MASK) == (pADDR_WIDTH'(base) & WORD_MASK);
  endfunction

  state_e                 state_r, state_s;
  logic                   aw_full_r, w_full_r, rvalid_r;
  logic [pADDR_WIDTH-1:0] aw_addr_r;
  logic [pDATA_WIDTH-1:0] w_data_r, rdata_r, rd_val_s, ctrl_s;
  logic                   ap_start_r, ap_done_r, tlast_err_r;
  logic [pDATA_WIDTH-1:0] data_len_r, gain_r, in_cnt_r, out_cnt_r, last_idx_s, product_s;
  logic                   aw_hs_s, w_hs_s, ar_hs_s, wr_commit_s, idle_s, start_s;
  logic                   wr_len_s, wr_gain_s, rd_ctrl_s;
  logic                   fifo_full_s, fifo_empty_s, pop_s, ss_ready_s, ss_hs_s;
  logic                   in_last_s, out_last_s, done_set_s;
  logic [pDATA_WIDTH-1:0] fifo_head_s;

  assign aw_hs_s     = bus.awvalid & ~aw_full_r;
  assign w_hs_s      = bus.wvalid & ~w_full_r;
  assign ar_hs_s     = bus.arvalid & ~rvalid_r;
  assign wr_commit_s = aw_full_r & w_full_r;
  assign idle_s      = (state_r == IDLE);
  assign start_s     = wr_commit_s & addr_hit(aw_addr_r, ADDR_AP_CTRL) & w_data_r[AP_START_BIT] & idle_s;
  assign wr_len_s    = wr_commit_s & addr_hit(aw_addr_r, ADDR_DATA_LEN);
  assign wr_gain_s   = wr_commit_s & addr_hit(aw_addr_r, ADDR_GAIN);
  assign rd_ctrl_s   = ar_hs_s & addr_hit(bus.araddr, ADDR_AP_CTRL);

  assign last_idx_s  = data_len_r - ONE;
  assign in_last_s   = (in_cnt_r == last_idx_s);
  assign out_last_s  = (out_cnt_r == last_idx_s);
  assign product_s   = gain_r * bus.ss_tdata;
  assign pop_s       = ~fifo_empty_s & bus.sm_tready;
  assign ss_ready_s  = (state_r == RUN) & (in_cnt_r != data_len_r) & (~fifo_full_s | pop_s);
  assign ss_hs_s     = bus.ss_tvalid & ss_ready_s;
  assign done_set_s  = ((state_r == RUN) & (data_len_r == '0)) |
                       ((state_r == DRAIN) & pop_s & out_last_s);

  assign bus.awready   = ~aw_full_r;
  assign bus.wready    = ~w_full_r;
  assign bus.arready   = ~rvalid_r;
  assign bus.rvalid    = rvalid_r;
  assign bus.rdata     = rdata_r;
  assign bus.ss_tready = ss_ready_s;
  assign bus.sm_tvalid = ~fifo_empty_s;
  assign bus.sm_tdata  = fifo_head_s;
  assign bus.sm_tlast  = ~fifo_empty_s & out_last_s;

  axis_sync_fifo #(.WIDTH(pDATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .wbs_clk_i (wbs_clk_i),
    .wbs_rst_i (wbs_rst_i),
    .push      (ss_hs_s),
    .push_data (product_s),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Register read mux, sampled at the AR handshake so it sees pre-commit values
  always_comb begin
    ctrl_s                = '0;
    ctrl_s[AP_START_BIT]  = ap_start_r;
    ctrl_s[AP_DONE_BIT]   = ap_done_r;
    ctrl_s[AP_IDLE_BIT]   = idle_s;
    ctrl_s[TLAST_ERR_BIT] = tlast_err_r;
    if (addr_hit(bus.araddr, ADDR_AP_CTRL)) begin
      rd_val_s = ctrl_s;
    end else if (addr_hit(bus.araddr, ADDR_DATA_LEN)) begin
      rd_val_s = data_len_r;
    end else if (addr_hit(bus.araddr, ADDR_GAIN)) begin
      rd_val_s = gain_r;
    end else begin
      rd_val_s = '0;
    end
  end

  // Block sequencing next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = RUN;
        else         state_s = IDLE;
      end
      RUN: begin
        if (data_len_r == '0)         state_s = IDLE;
        else if (ss_hs_s & in_last_s) state_s = DRAIN;
        else                          state_s = RUN;
      end
      DRAIN: begin
        if (pop_s & out_last_s) state_s = IDLE;
        else                    state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) state_r <= IDLE;
    else            state_r <= state_s;
  end

  // AW/W holding slots; both drain together on the commit cycle
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      aw_full_r <= 1'b0;
      aw_addr_r <= '0;
      w_full_r  <= 1'b0;
      w_data_r  <= '0;
    end else if (wr_commit_s) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_full_r <= 1'b1;
        aw_addr_r <= bus.awaddr;
      end
      if (w_hs_s) begin
        w_full_r <= 1'b1;
        w_data_r <= bus.wdata;
      end
    end
  end

  // Read response channel
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_val_s;
    end else if (bus.rready) begin
      rvalid_r <= 1'b0;
    end
  end

  // Control/status registers and block counters; a done-set outranks clear-on-read
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      ap_start_r  <= 1'b0;
      ap_done_r   <= 1'b0;
      tlast_err_r <= 1'b0;
      data_len_r  <= '0;
      gain_r      <= '0;
      in_cnt_r    <= '0;
      out_cnt_r   <= '0;
    end else begin
      if (start_s)                    ap_start_r <= 1'b1;
      else if (ss_hs_s | done_set_s)  ap_start_r <= 1'b0;
      if (done_set_s)                 ap_done_r <= 1'b1;
      else if (start_s | rd_ctrl_s)   ap_done_r <= 1'b0;
      if (start_s)                                      tlast_err_r <= 1'b0;
      else if (ss_hs_s && (bus.ss_tlast != in_last_s))  tlast_err_r <= 1'b1;
      if (wr_len_s & idle_s)  data_len_r <= w_data_r;
      if (wr_gain_s & idle_s) gain_r     <= w_data_r;
      if (start_s)      in_cnt_r <= '0;
      else if (ss_hs_s) in_cnt_r <= in_cnt_r + ONE;
      if (start_s)      out_cnt_r <= '0;
      else if (pop_s)   out_cnt_r <= out_cnt_r + ONE;
    end
  end

endmodule

// File: tb/tb_axil_axis_responder.sv
// Randomized self-checking bench for axil_axis_responder against a queue-based reference model.
module tb_axil_axis_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;

  always #5 clk = ~clk;

  axil_axis_responder_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  axil_axis_responder #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .wbs_clk_i (clk),
    .wbs_rst_i (rst_n),
    .bus       (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axil_write(input logic [11:0] addr, input logic [31:0] data);
    int   t    = 0;
    logic aw_ok = 1'b0;
    logic w_ok  = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = addr;
    bus.wvalid  = 1'b1; bus.wdata  = data;
    while (!(aw_ok && w_ok) && t < 20) begin
      @(negedge clk);
      if (bus.awvalid && bus.awready) aw_ok = 1'b1;
      if (bus.wvalid && bus.wready)   w_ok  = 1'b1;
      @(posedge clk); #1;
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok)  bus.wvalid  = 1'b0;
      t++;
    end
    check_val("wr_accept", {30'd0, aw_ok, w_ok}, 32'd3);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic axil_read(input logic [11:0] addr, output logic [31:0] data);
    int t = 0;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.rready = 1'b1;
    @(negedge clk);
    while (!bus.arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("arready", 32'(bus.arready), 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check_val("rvalid_lat", 32'(bus.rvalid), 32'd1);
    data = bus.rdata;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  // One block: configure, stream len samples, compare against gain*sample model.
  task automatic run_block(input int len, input logic [31:0] gain, input int tlast_pos,
                           input int stall, input bit gaps, input bit poke, input bit seq);
    logic [31:0] smp[$];
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] d;
    bit          err = 1'b0;
    for (int i = 0; i < len; i++) begin
      d = seq ? 32'(i + 1) : $urandom;
      smp.push_back(d);
      exp_q.push_back(gain * d);
      if ((i == tlast_pos) != (i == len - 1)) err = 1'b1;
    end
    axil_write(12'h020, gain);
    axil_write(12'h010, 32'(len));
    axil_write(12'h000, 32'd1);
    n_acc = 0;
    fork
      begin : prod
        int i = 0;
        int t = 0;
        while (i < len && t < 400) begin
          if (gaps && $urandom_range(0, 3) == 0) begin
            bus.ss_tvalid = 1'b0;
          end else begin
            bus.ss_tvalid = 1'b1;
            bus.ss_tdata  = smp[i];
            bus.ss_tlast  = (i == tlast_pos);
          end
          @(negedge clk);
          if (bus.ss_tvalid && bus.ss_tready) begin
            i++;
            n_acc++;
          end
          @(posedge clk); #1;
          t++;
        end
        bus.ss_tvalid = 1'b0;
        bus.ss_tlast  = 1'b0;
        check_val("ss_all_sent", 32'(i), 32'(len));
      end
      begin : cons
        int          k = 0;
        int          t = 0;
        logic        held = 1'b0;
        logic [31:0] hdata = 32'd0;
        while (k < len && t < 400) begin
          if (t < stall) bus.sm_tready = 1'b0;
          else           bus.sm_tready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
          @(negedge clk);
          if (held) begin
            check_val("hold_valid", 32'(bus.sm_tvalid), 32'd1);
            check_val("hold_data", bus.sm_tdata, hdata);
          end
          if (stall >= 6 && t == stall - 1) begin
            check_val("stall_accepts", 32'(n_acc), 32'd4);
            check_val("stall_ss_tready", 32'(bus.ss_tready), 32'd0);
          end
          if (bus.sm_tvalid) begin
            check_val("sm_tlast", 32'(bus.sm_tlast), 32'(k == len - 1));
            if (bus.sm_tready) begin
              check_val("sm_data", bus.sm_tdata, exp_q[k]);
              k++;
            end
          end
          held  = bus.sm_tvalid && !bus.sm_tready;
          hdata = bus.sm_tdata;
          @(posedge clk); #1;
          t++;
        end
        bus.sm_tready = 1'b0;
        check_val("sm_all_recv", 32'(k), 32'(len));
      end
      begin : poke_gain
        if (poke) begin
          repeat (3) @(posedge clk);
          #1;
          axil_write(12'h020, 32'd7);
        end
      end
    join
    @(posedge clk); #1;
    axil_read(12'h000, rd);
    check_val("ctrl_done", rd, 32'h6 | (err ? 32'h8 : 32'h0));
    axil_read(12'h000, rd);
    check_val("ctrl_cor", rd, 32'h4 | (err ? 32'h8 : 32'h0));
    axil_read(12'h020, rd);
    check_val("gain_kept", rd, gain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    int          t;
    int          len;
    bus.awvalid = 1'b0; bus.awaddr = 12'h0; bus.wvalid = 1'b0; bus.wdata = 32'd0;
    bus.arvalid = 1'b0; bus.araddr = 12'h0; bus.rready = 1'b0;
    bus.ss_tvalid = 1'b0; bus.ss_tdata = 32'd0; bus.ss_tlast = 1'b0; bus.sm_tready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check_val("rst_awready", 32'(bus.awready), 32'd1);
    check_val("rst_wready", 32'(bus.wready), 32'd1);
    check_val("rst_arready", 32'(bus.arready), 32'd1);
    check_val("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_val("rst_rdata", bus.rdata, 32'd0);
    check_val("rst_ss_tready", 32'(bus.ss_tready), 32'd0);
    check_val("rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    check_val("rst_sm_tdata", bus.sm_tdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    axil_read(12'h000, rd);
    check_val("ctrl_reset", rd, 32'h4);

    // AW arrives well ahead of W: nothing commits until both are held
    bus.awvalid = 1'b1; bus.awaddr = 12'h020;
    @(negedge clk);
    check_val("awready_empty", 32'(bus.awready), 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    @(negedge clk);
    check_val("awready_held", 32'(bus.awready), 32'd0);
    check_val("wready_open", 32'(bus.wready), 32'd1);
    @(posedge clk); #1;
    axil_read(12'h020, rd);
    check_val("gain_before_w", rd, 32'd0);
    bus.wvalid = 1'b1; bus.wdata = 32'd9;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    @(negedge clk);
    check_val("awready_commit", 32'(bus.awready), 32'd0);
    @(negedge clk);
    check_val("awready_reopen", 32'(bus.awready), 32'd1);
    @(posedge clk); #1;
    axil_read(12'h020, rd);
    check_val("gain_after_w", rd, 32'd9);
    axil_read(12'h022, rd);
    check_val("gain_low_bits", rd, 32'd9);

    axil_write(12'h030, 32'hDEAD_BEEF);
    axil_read(12'h030, rd);
    check_val("unmapped_rd", rd, 32'd0);
    axil_read(12'h014, rd);
    check_val("unmapped_gap", rd, 32'd0);

    run_block(5, 32'd3, 4, 0, 1'b0, 1'b0, 1'b1);
    run_block(5, 32'd3, 4, 10, 1'b0, 1'b0, 1'b1);

    // Zero-length block completes with no stream traffic
    axil_write(12'h010, 32'd0);
    axil_write(12'h000, 32'd1);
    @(negedge clk);
    check_val("zero_ss_tready", 32'(bus.ss_tready), 32'd0);
    check_val("zero_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    @(posedge clk); #1;
    axil_read(12'h000, rd);
    check_val("zero_ctrl", rd, 32'h6);
    axil_read(12'h000, rd);
    check_val("zero_ctrl_cor", rd, 32'h4);

    run_block(5, 32'd3, 1, 6, 1'b0, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 9);
      run_block(len, $urandom, ($urandom_range(0, 1) == 1) ? len - 1 : $urandom_range(0, len - 1),
                $urandom_range(0, 8), 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of a block with two results waiting
    axil_write(12'h020, 32'd3);
    axil_write(12'h010, 32'd5);
    axil_write(12'h000, 32'd1);
    bus.sm_tready = 1'b0;
    n = 0;
    t = 0;
    while (n < 2 && t < 50) begin
      bus.ss_tvalid = 1'b1;
      bus.ss_tdata  = 32'(n + 1);
      @(negedge clk);
      if (bus.ss_tvalid && bus.ss_tready) n++;
      @(posedge clk); #1;
      t++;
    end
    bus.ss_tvalid = 1'b0;
    check_val("pre_rst_accepts", 32'(n), 32'd2);
    check_val("pre_rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    check_val("mid_rst_ss_tready", 32'(bus.ss_tready), 32'd0);
    check_val("mid_rst_sm_tdata", bus.sm_tdata, 32'd0);
    check_val("mid_rst_sm_tlast", 32'(bus.sm_tlast), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    axil_read(12'h000, rd);
    check_val("post_rst_ctrl", rd, 32'h4);
    axil_read(12'h020, rd);
    check_val("post_rst_gain", rd, 32'd0);
    @(negedge clk);
    check_val("post_rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
